// File: rtl/uart_duplex_param.sv
// Full-duplex UART with a configurable frame format and a fall-through RX FIFO.
// The RX line is synchronized before use. Each RX bit is sampled near its midpoint.
// Completed words are queued together with their parity and framing error flags.
module uart_duplex_param #(
    parameter int unsigned CLK_DIV    = 5208,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned RX_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_send,
    output logic                 tx_busy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_rd,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    input  logic                 err_clr
);

    localparam int unsigned AW       = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int unsigned EW       = DATA_BITS + 2;
    localparam logic [15:0] DivLast  = 16'(CLK_DIV - 1);
    localparam logic [15:0] DivHalf  = 16'(CLK_DIV / 2);
    localparam logic [3:0]  DataLast = 4'(DATA_BITS - 1);
    localparam logic [3:0]  StopLast = 4'(STOP_BITS - 1);
    localparam logic        ParOn    = (PARITY_EN != 0);
    localparam logic        ParInv   = (PARITY_ODD != 0);
    localparam logic [AW:0] DepthCnt = (AW + 1)'(RX_DEPTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    // ---------------- RX synchronizer ----------------
    logic rx_meta_q, rxs_q, rxs_prev_q;

    // Two-flop synchronizer plus one delayed copy for start-edge detection.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            rx_meta_q  <= rx;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    // ---------------- RX FSM ----------------
    state_e               rx_state_q, rx_state_d;
    logic [15:0]          rx_cnt_q, rx_cnt_d;
    logic [3:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 push;

    // RX next-state: START samples at the half-bit point, later bits one full bit apart.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 16'd1;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        push       = 1'b0;
        unique case (rx_state_q)
            StIdle: begin
                rx_cnt_d = 16'd0;
                if (rxs_prev_q && !rxs_q) rx_state_d = StStart;
            end
            StStart: begin
                if (rx_cnt_q == DivHalf) begin
                    rx_cnt_d   = 16'd0;
                    rx_bit_d   = 4'd0;
                    rx_perr_d  = 1'b0;
                    rx_ferr_d  = 1'b0;
                    // A start bit that is high again by mid-bit is a glitch.
                    rx_state_d = rxs_q ? StIdle : StData;
                end
            end
            StData: begin
                if (rx_cnt_q == DivLast) begin
                    rx_cnt_d = 16'd0;
                    rx_sh_d  = {rxs_q, rx_sh_q[DATA_BITS-1:1]};
                    if (rx_bit_q == DataLast) begin
                        rx_bit_d   = 4'd0;
                        rx_state_d = ParOn ? StParity : StStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end
            end
            StParity: begin
                if (rx_cnt_q == DivLast) begin
                    rx_cnt_d   = 16'd0;
                    rx_perr_d  = (^rx_sh_q) ^ rxs_q ^ ParInv;
                    rx_state_d = StStop;
                end
            end
            StStop: begin
                if (rx_cnt_q == DivLast) begin
                    rx_cnt_d  = 16'd0;
                    rx_ferr_d = rx_ferr_q | ~rxs_q;
                    if (rx_bit_q == StopLast) begin
                        rx_bit_d   = 4'd0;
                        push       = 1'b1;
                        rx_state_d = StIdle;
                    end else begin
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end
            end
            default: rx_state_d = StIdle;
        endcase
    end

    // RX state registers.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rx_state_q <= StIdle;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 4'd0;
            rx_sh_q    <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [EW-1:0] fifo_mem [RX_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          overrun_q;
    logic          pop, full, write, overrun_set;

    assign pop         = rx_rd && (count_q != '0);
    assign full        = (count_q == DepthCnt);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign write       = push && (!full || pop);
    assign overrun_set = push && full && !pop;

    // FIFO storage; contents need no reset because count_q gates visibility.
    always_ff @(posedge clk) begin
        if (write) fifo_mem[wr_ptr_q] <= {rx_sh_q, rx_perr_q, rx_ferr_d};
    end

    // FIFO pointers, occupancy and sticky overrun.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (write) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW + 1)'(write) - (AW + 1)'(pop);
            if (overrun_set)  overrun_q <= 1'b1;
            else if (err_clr) overrun_q <= 1'b0;
        end
    end

    assign rx_valid      = (count_q != '0);
    assign rx_data       = fifo_mem[rd_ptr_q][EW-1:2];
    assign rx_parity_err = fifo_mem[rd_ptr_q][1] & ParOn;
    assign rx_frame_err  = fifo_mem[rd_ptr_q][0];
    assign rx_overrun    = overrun_q;

    // ---------------- TX FSM ----------------
    state_e               tx_state_q, tx_state_d;
    logic [15:0]          tx_cnt_q, tx_cnt_d;
    logic [3:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_q, tx_d;

    // TX next-state; tx_d is the line level for the state being entered, so tx is registered.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 16'd1;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        unique case (tx_state_q)
            StIdle: begin
                tx_cnt_d = 16'd0;
                tx_d     = 1'b1;
                if (tx_send) begin
                    tx_state_d = StStart;
                    tx_bit_d   = 4'd0;
                    tx_sh_d    = tx_data;
                    tx_par_d   = (^tx_data) ^ ParInv;
                    tx_d       = 1'b0;
                end
            end
            StStart: begin
                if (tx_cnt_q == DivLast) begin
                    tx_cnt_d   = 16'd0;
                    tx_state_d = StData;
                    tx_d       = tx_sh_q[0];
                end
            end
            StData: begin
                if (tx_cnt_q == DivLast) begin
                    tx_cnt_d = 16'd0;
                    tx_sh_d  = tx_sh_q >> 1;
                    if (tx_bit_q == DataLast) begin
                        tx_bit_d   = 4'd0;
                        tx_state_d = ParOn ? StParity : StStop;
                        tx_d       = ParOn ? tx_par_q : 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                        tx_d     = tx_sh_q[1];
                    end
                end
            end
            StParity: begin
                if (tx_cnt_q == DivLast) begin
                    tx_cnt_d   = 16'd0;
                    tx_state_d = StStop;
                    tx_d       = 1'b1;
                end
            end
            StStop: begin
                if (tx_cnt_q == DivLast) begin
                    tx_cnt_d = 16'd0;
                    tx_d     = 1'b1;
                    if (tx_bit_q == StopLast) begin
                        tx_bit_d   = 4'd0;
                        tx_state_d = StIdle;
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end
            end
            default: begin
                tx_state_d = StIdle;
                tx_d       = 1'b1;
            end
        endcase
    end

    // TX state registers.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            tx_state_q <= StIdle;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 4'd0;
            tx_sh_q    <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = (tx_state_q != StIdle);

endmodule

// File: tb/tb_uart_duplex_param.sv
// Directed bench for uart_duplex_param at CLK_DIV=16, 8E1, RX_DEPTH=4.
module tb_uart_duplex_param;

    localparam int unsigned DIV = 16;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       rx, tx;
    logic [7:0] tx_data = 8'h00;
    logic       tx_send = 1'b0;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_rd = 1'b0;
    logic       rx_parity_err, rx_frame_err, rx_overrun;
    logic       err_clr = 1'b0;
    logic       loop = 1'b0;
    logic       rx_drv = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    assign rx = loop ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_duplex_param #(
        .CLK_DIV   (DIV),
        .DATA_BITS (8),
        .PARITY_EN (1),
        .PARITY_ODD(0),
        .STOP_BITS (1),
        .RX_DEPTH  (4)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .rx           (rx),
        .tx           (tx),
        .tx_data      (tx_data),
        .tx_send      (tx_send),
        .tx_busy      (tx_busy),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_rd        (rx_rd),
        .rx_parity_err(rx_parity_err),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun),
        .err_clr      (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rx_bit(input logic b);
        rx_drv = b;
        cyc(DIV);
    endtask

    // One 8E1 frame on rx_drv, optional parity flip and stop level, then one idle bit.
    task automatic rx_frame(input logic [7:0] d, input logic flip, input logic stop);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(d[i]);
        rx_bit((^d) ^ flip);
        rx_bit(stop);
        rx_bit(1'b1);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 64 && !rx_valid; i++) @(negedge clk);
        check(tag, 32'(rx_valid), 32'd1);
    endtask

    task automatic pop();
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         busy_cnt;
        int         low_run;
        logic       still_low;
        logic [7:0] d;

        // Reset values
        cyc(3);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_overrun", 32'(rx_overrun), 32'd0);
        n_rst = 1'b1;
        cyc(2);

        // Loopback 0xA5, with an extra send mid-frame that must be ignored
        loop    = 1'b1;
        tx_data = 8'hA5;
        tx_send = 1'b1;
        @(negedge clk);
        tx_send   = 1'b0;
        tx_data   = 8'h3F;
        busy_cnt  = 0;
        low_run   = 0;
        still_low = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!tx_busy) break;
            busy_cnt++;
            if (still_low && tx === 1'b0) low_run++;
            else still_low = 1'b0;
            tx_send = (i == 50);
            @(negedge clk);
        end
        tx_send = 1'b0;
        check("busy_cycles", 32'(busy_cnt), 32'd176);
        check("start_low", 32'(low_run), 32'd16);
        wait_valid("lb_valid");
        check("lb_data", 32'(rx_data), 32'hA5);
        check("lb_perr", 32'(rx_parity_err), 32'd0);
        check("lb_ferr", 32'(rx_frame_err), 32'd0);
        cyc(40);
        check("ignored_busy", 32'(tx_busy), 32'd0);
        check("ignored_tx", 32'(tx), 32'd1);
        pop();
        check("lb_one_entry", 32'(rx_valid), 32'd0);
        loop   = 1'b0;
        rx_drv = 1'b1;
        cyc(4);

        // Clean frame with odd popcount
        rx_frame(8'h07, 1'b0, 1'b1);
        wait_valid("ok_valid");
        check("ok_data", 32'(rx_data), 32'h07);
        check("ok_perr", 32'(rx_parity_err), 32'd0);
        check("ok_ferr", 32'(rx_frame_err), 32'd0);
        pop();

        // Parity error
        rx_frame(8'h3C, 1'b1, 1'b1);
        wait_valid("pe_valid");
        check("pe_data", 32'(rx_data), 32'h3C);
        check("pe_perr", 32'(rx_parity_err), 32'd1);
        check("pe_ferr", 32'(rx_frame_err), 32'd0);
        pop();
        check("pe_one_entry", 32'(rx_valid), 32'd0);

        // Framing error
        rx_frame(8'h81, 1'b0, 1'b0);
        wait_valid("fe_valid");
        check("fe_data", 32'(rx_data), 32'h81);
        check("fe_perr", 32'(rx_parity_err), 32'd0);
        check("fe_ferr", 32'(rx_frame_err), 32'd1);
        pop();

        // Overrun: five frames into a 4-deep FIFO
        for (int k = 1; k <= 5; k++) rx_frame(8'(k), 1'b0, 1'b1);
        check("ovr_set", 32'(rx_overrun), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("ovr_clr", 32'(rx_overrun), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            check("ovr_valid", 32'(rx_valid), 32'd1);
            check("ovr_data", 32'(rx_data), 32'(k));
            pop();
        end
        check("ovr_empty", 32'(rx_valid), 32'd0);

        // Glitch on rx: four low cycles only
        rx_drv = 1'b0;
        cyc(4);
        rx_drv = 1'b1;
        cyc(40);
        check("glitch_none", 32'(rx_valid), 32'd0);

        // Reset mid-frame: TX in data bit 3, RX in data bit 5
        d       = 8'hA6;
        tx_data = 8'h5A;
        for (int c = 0; c < 100; c++) begin
            rx_drv  = (c < 16) ? 1'b0 : d[(c / 16) - 1];
            tx_send = (c == 30);
            @(negedge clk);
        end
        n_rst = 1'b0;
        @(negedge clk);
        n_rst  = 1'b1;
        rx_drv = 1'b1;
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_busy", 32'(tx_busy), 32'd0);
        check("mid_rst_valid", 32'(rx_valid), 32'd0);
        cyc(40);
        check("mid_rst_nopush", 32'(rx_valid), 32'd0);
        check("mid_rst_noresume", 32'(tx_busy), 32'd0);
        rx_frame(8'hC3, 1'b0, 1'b1);
        wait_valid("post_rst_valid");
        check("post_rst_data", 32'(rx_data), 32'hC3);
        check("post_rst_perr", 32'(rx_parity_err), 32'd0);
        check("post_rst_ferr", 32'(rx_frame_err), 32'd0);
        pop();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
